// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the uart_rx_port receiver slice.
//   - Receiver FSM state encoding (legacy-compatible logic constants).
//   - Register word offsets and STATUS/CTRL bit positions.
//   - STATUS payload struct and an even-parity helper.
package uart_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Receiver FSM states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Register word offsets
    localparam logic [ADDR_W-1:0] REG_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS = 2'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 2'd2;

    // STATUS bit indices
    localparam int unsigned STAT_VALID = 0;
    localparam int unsigned STAT_OVR   = 1;
    localparam int unsigned STAT_FERR  = 2;
    localparam int unsigned STAT_FULL  = 3;
    localparam int unsigned STAT_PERR  = 8;

    // CTRL bit indices
    localparam int unsigned CTRL_IE = 0;

    // STATUS register payload, bit 8 down to bit 0
    typedef struct packed {
        logic       perr;
        logic [3:0] count;
        logic       full;
        logic       ferr;
        logic       ovr;
        logic       valid;
    } status_t;

    // Even-parity bit that makes the 9-bit word have an even number of ones
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// uart_rx_port_if: CPU-side register bus of the UART receiver.
//   addr  word offset (DATA/STATUS/CTRL/reserved)
//   we    write strobe, one cycle
//   re    read strobe, one cycle; qualifies the DATA pop
//   din   write data
//   dout  read data, combinational from addr
//   irq   level interrupt request, registered
interface uart_rx_port_if;
    import uart_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              irq;

    modport master (
        output addr, we, re, din,
        input  dout, irq
    );

    modport slave (
        input  addr, we, re, din,
        output dout, irq
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO for received characters.
//   clk, reset   clock and synchronous active-high reset
//   push, wdata  write request and byte (ignored when full unless popping)
//   pop, rdata   read request (ignored when empty) and head byte
//   full, empty  occupancy flags derived from the registered count
//   count        number of stored bytes
// Simultaneous push and pop are legal in every state; a pop frees the slot
// that the push in the same cycle then uses.
module uart_rx_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // Pop is resolved first so a push into a full FIFO can reuse the freed slot
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// uart_rx_port: memory-mapped UART receiver (8N1, or 8E1 when the
// UART_RX_PARITY_EN macro is defined).
//   clk       system clock
//   reset     synchronous active-high reset
//   uart_rxd  asynchronous serial input, idles high
//   bus       register slave: DATA(0) pops the FIFO head on re, STATUS(1)
//             reports valid/ovr/ferr/full/count (+perr) with W1C clears,
//             CTRL(2) holds the interrupt enable, offset 3 is reserved
// irq is a registered level request: ie & (data pending | any error flag).
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rxd,
    uart_rx_port_if.slave bus
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    // Receive path state
    logic [1:0]    r_sync;
    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          w_rxd_s;

    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_push;
    logic          w_ferr_set;

    // Register file state
    logic          r_ovr;
    logic          r_ferr;
    logic          r_ie;
    logic          r_irq;

`ifdef UART_RX_PARITY_EN
    logic          r_perr;
    logic          r_par_bad;
    logic          w_perr_set;
    logic          w_par_bad_nxt;
`endif

    // FIFO and bus decode
    logic [7:0]    w_rdata;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          w_ovr_set;
    logic          w_stat_wr;
    logic          w_err_any;
    status_t       w_status;
    logic [31:0]   w_dout;
    logic          w_unused_din;

    assign w_rxd_s = r_sync[1];

    // Next-state and frame-event logic for the deframer
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TW'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_set    = 1'b0;
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (!w_rxd_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Half-bit check rejects glitches and aligns later samples mid-bit
                if (r_timer == HALF_LAST) begin
                    w_timer_nxt = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_nxt = '0;
                    w_shift_nxt = {w_rxd_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_nxt   = '0;
                    w_par_bad_nxt = (even_parity(r_shift) != w_rxd_s);
                    w_perr_set    = w_par_bad_nxt;
                    w_state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_nxt = '0;
                    if (w_rxd_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must return high before a new frame
                w_timer_nxt = '0;
                if (w_rxd_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Synchroniser and deframer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= 2'b11;
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync    <= {r_sync[0], uart_rxd};
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (r_shift),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Bus-side decode; the pushed byte is r_shift, complete once STOP is reached
    assign w_pop     = bus.re & (bus.addr == REG_DATA) & ~w_empty;
    assign w_ovr_set = w_push & w_full & ~w_pop;
    assign w_stat_wr = bus.we & (bus.addr == REG_STATUS);

`ifdef UART_RX_PARITY_EN
    assign w_err_any = r_ovr | r_ferr | r_perr;
`else
    assign w_err_any = r_ovr | r_ferr;
`endif

    // Error flags, interrupt enable and interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_ie   <= 1'b0;
            r_irq  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
        end else begin
            // Set wins over a same-cycle W1C so no error is lost
            r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_stat_wr & bus.din[STAT_OVR]));
            r_ferr <= w_ferr_set | (r_ferr & ~(w_stat_wr & bus.din[STAT_FERR]));
`ifdef UART_RX_PARITY_EN
            r_perr <= w_perr_set | (r_perr & ~(w_stat_wr & bus.din[STAT_PERR]));
`endif
            if (bus.we && (bus.addr == REG_CTRL)) begin
                r_ie <= bus.din[CTRL_IE];
            end
            r_irq <= r_ie & (~w_empty | w_err_any);
        end
    end

    // STATUS payload
    always_comb begin
        w_status       = '0;
        w_status.valid = ~w_empty;
        w_status.ovr   = r_ovr;
        w_status.ferr  = r_ferr;
        w_status.full  = w_full;
        w_status.count = 4'(w_count);
`ifdef UART_RX_PARITY_EN
        w_status.perr  = r_perr;
`endif
    end

    // Read mux
    always_comb begin
        w_dout = '0;
        case (bus.addr)
            REG_DATA:   w_dout = w_empty ? 32'd0 : {24'd0, w_rdata};
            REG_STATUS: w_dout = {23'd0, w_status};
            REG_CTRL:   w_dout = {31'd0, r_ie};
            default:    w_dout = '0;
        endcase
    end

    assign bus.dout = w_dout;
    assign bus.irq  = r_irq;

    // Write-data bits with no register behind them
    assign w_unused_din = ^bus.din;

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: directed bench for uart_rx_port (8N1 build, 16 clocks/bit,
// 4-entry FIFO). A frame-level model (byte queue + flags) predicts every
// register read and the registered irq; literal checks pin key values.
module tb_uart_rx_port;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset;
    logic uart_rxd;

    always #5 clk = ~clk;

    uart_rx_port_if bus ();

    uart_rx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model
    logic [7:0] m_q[$];
    bit         m_ovr;
    bit         m_ferr;
    bit         m_ie;

    bit         chk_en  = 1'b0;
    bit         prev_ok = 1'b0;
    logic       prev_irq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: if (m_q.size() != 0) v = {24'd0, m_q[0]};
            2'd1: begin
                v[0]   = (m_q.size() != 0);
                v[1]   = m_ovr;
                v[2]   = m_ferr;
                v[3]   = (m_q.size() == DEPTH);
                v[7:4] = 4'(m_q.size());
            end
            2'd2: v[0] = m_ie;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic model_irq();
        return m_ie & ((m_q.size() != 0) | m_ovr | m_ferr);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_ie   = 1'b0;
    endtask

    // Per-cycle compare: dout against the model, irq one cycle behind it
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", bus.dout, model_dout(bus.addr));
            if (prev_ok) check("irq", {31'd0, bus.irq}, {31'd0, prev_irq});
        end
        prev_irq = reset ? 1'b0 : model_irq();
        prev_ok  = chk_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        bus.re   = 1'b1;
        @(negedge clk);
        v = bus.dout;
        tick();
        bus.re   = 1'b0;
        bus.addr = 2'd1;
        if (a == 2'd0 && m_q.size() != 0) m_q.delete(0);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        tick();
        bus.we   = 1'b0;
        bus.din  = '0;
        bus.addr = 2'd1;
        if (a == 2'd1) begin
            if (d[1]) m_ovr  = 1'b0;
            if (d[2]) m_ferr = 1'b0;
        end else if (a == 2'd2) begin
            m_ie = d[0];
        end
    endtask

    // One 8N1 frame. probe: pin irq timing around the push (expects empty
    // FIFO, ie=1). pop_at_stop: pop the head on the same edge as the push.
    // abort_at: cycle at which a reset pulse cuts the frame (-1 = never).
    task automatic send_frame(input logic [7:0] b, input bit probe,
                              input bit pop_at_stop, input int abort_at);
        for (int c = 0; c < FRAME; c++) begin
            if (c == abort_at) begin
                reset    = 1'b1;
                uart_rxd = 1'b1;
                tick();
                reset = 1'b0;
                model_reset();
                return;
            end
            if (c < CPB)          uart_rxd = 1'b0;
            else if (c < 9 * CPB) uart_rxd = b[(c - CPB) / CPB];
            else                  uart_rxd = 1'b1;
            // The push lands mid stop bit; the model catches up at frame end
            if (c == 150) chk_en = 1'b0;
            if (pop_at_stop && c == 154) begin
                bus.addr = 2'd0;
                bus.re   = 1'b1;
            end
            if (pop_at_stop && c == 155) begin
                bus.re   = 1'b0;
                bus.addr = 2'd1;
                m_q.delete(0);
            end
            tick();
            if (probe && c == 154) check("irq_before_push", {31'd0, bus.irq}, 32'd0);
            if (probe && c == 155) check("irq_after_push", {31'd0, bus.irq}, 32'd1);
        end
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else                    m_ovr = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        bus.addr = 2'd1;
        bus.we   = 1'b0;
        bus.re   = 1'b0;
        bus.din  = '0;
        model_reset();
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and register map corners
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        bus_read(2'd1, v); check("reset_status", v, 32'h0);
        bus_read(2'd0, v); check("empty_data", v, 32'h0);
        bus_read(2'd2, v); check("reset_ctrl", v, 32'h0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, v); check("reserved_read", v, 32'h0);
        bus_read(2'd2, v); check("reserved_no_ctrl", v, 32'h0);
        repeat (5) tick();

        // Single frame
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        bus_read(2'd1, v); check("a5_status", v, 32'h11);
        bus_read(2'd0, v); check("a5_data", v, 32'hA5);
        bus_read(2'd1, v); check("a5_status_after", v, 32'h00);

        // Overrun: five frames into four slots
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, -1);
        bus_read(2'd1, v); check("ovr_status", v, 32'h4B);
        for (int i = 1; i <= 4; i++) begin
            bus_read(2'd0, v); check("ovr_data", v, 32'(i));
        end
        bus_read(2'd1, v); check("ovr_sticky", v, 32'h02);
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, v); check("ovr_cleared", v, 32'h00);

        // Push into a full FIFO with a pop on the same edge
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, -1);
        send_frame(8'h15, 1'b0, 1'b1, -1);
        bus_read(2'd1, v); check("pushpop_status", v, 32'h49);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, v); check("pushpop_data", v, 32'h12 + 32'(i));
        end

        // Break from reset release: one ferr only
        reset    = 1'b1;
        uart_rxd = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < FRAME; c++) begin
            if (c == 150) chk_en = 1'b0;
            tick();
        end
        m_ferr = 1'b1;
        chk_en = 1'b1;
        bus_read(2'd1, v); check("break_status", v, 32'h04);
        bus_write(2'd1, 32'h4);
        repeat (250) tick();
        uart_rxd = 1'b1;
        repeat (40) tick();
        bus_read(2'd1, v); check("break_single_ferr", v, 32'h00);
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        bus_read(2'd0, v); check("after_break_data", v, 32'h3C);

        // Short low glitch on an idle line
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (40) tick();
        bus_read(2'd1, v); check("glitch_status", v, 32'h00);

        // Interrupt enabled
        bus_write(2'd2, 32'h1);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        bus_read(2'd0, v); check("irq_data", v, 32'h7E);
        check("irq_hold", {31'd0, bus.irq}, 32'd1);
        tick();
        check("irq_drop", {31'd0, bus.irq}, 32'd0);

        // Interrupt disabled
        bus_write(2'd2, 32'h0);
        send_frame(8'h55, 1'b0, 1'b0, -1);
        repeat (4) tick();
        check("irq_masked", {31'd0, bus.irq}, 32'd0);
        bus_read(2'd0, v); check("masked_data", v, 32'h55);

        // Reset in the middle of bit 4
        bus_write(2'd2, 32'h1);
        send_frame(8'h99, 1'b0, 1'b0, -1);
        check("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
        send_frame(8'h66, 1'b0, 1'b0, 88);
        check("post_reset_irq", {31'd0, bus.irq}, 32'd0);
        bus_read(2'd1, v); check("post_reset_status", v, 32'h00);
        bus_read(2'd2, v); check("post_reset_ctrl", v, 32'h00);
        repeat (40) tick();
        send_frame(8'h81, 1'b0, 1'b0, -1);
        bus_read(2'd1, v); check("rx81_status", v, 32'h11);
        bus_read(2'd0, v); check("rx81_data", v, 32'h81);

        repeat (5) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- UART receiver peripheral that sits between the board pin uart_rxd and the CPU system bus, reached through the bridge.
- Samples a 2-flop-synchronised serial line and deframes 8N1 bytes.
- Buffers received bytes in a small FIFO and exposes them through memory-mapped DATA/STATUS/CTRL registers.
- Raises a level interrupt toward CP0 while data is pending and interrupts are enabled.

Parameters:
- CLKS_PER_BIT, 2604: clock cycles per bit; bench uses 16.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uart_rxd  in  1  asynchronous serial line, idles high
- addr  in  2  word offset: 0=DATA, 1=STATUS, 2=CTRL, 3=reserved
- we  in  1  bus write strobe, one cycle
- re  in  1  bus read strobe, one cycle; qualifies the DATA pop
- din  in  32  write data
- dout  out  32  read data, combinational from addr
- irq  out  1  interrupt request, registered

Behaviour:
- Reset values: dout reflects registers after reset, so STATUS=0 and DATA=0. irq=0. FIFO empty. Error flags=0. CTRL.ie=0. FSM=IDLE. Both synchroniser flops=1.
- Synchroniser: rxd_s is uart_rxd delayed by 2 flops. All decisions use rxd_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Bit timer counts 0..CLKS_PER_BIT-1. Bit index counts 0..7.
- IDLE: rxd_s==0 -> START, timer cleared.
- START: at timer==CLKS_PER_BIT/2-1, sample the line.
  - rxd_s==0 -> DATA, timer cleared, so later samples land mid-bit.
  - rxd_s==1 -> IDLE (glitch rejected; nothing recorded).
- DATA: every CLKS_PER_BIT cycles, shift rxd_s into the shift register LSB-first. After bit 7 -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample.
  - rxd_s==1: push the byte; FSM -> IDLE.
  - rxd_s==0: set ferr, discard the byte; FSM -> WAIT_HIGH.
- WAIT_HIGH: stays until rxd_s==1, then -> IDLE. A line held low (break) yields exactly one ferr and no further frames.
- Push into a full FIFO: byte dropped, ovr set, FIFO contents unchanged.
  - Exception: a pop in the same cycle frees a slot, so both succeed, count is unchanged and ovr is not set.
- DATA read (addr=0): dout={24'b0, head byte}.
  - re=1 with FIFO non-empty: pop at the clock edge.
  - FIFO empty: returns 0, no pop, no error.
- STATUS read (addr=1): bit0=!empty, bit1=ovr, bit2=ferr, bit3=full, bits[7:4]=count (zero-extended). Other bits 0.
- STATUS write: din bit1=1 clears ovr; din bit2=1 clears ferr (write-1-to-clear).
  - If a new error occurs in the same cycle as its clear, the flag stays set.
- CTRL (addr=2): bit0=ie, read/write. Other bits read 0, writes ignored.
- Reserved offset (addr=3): reads 0; writes ignored.
- irq register: next value = ie & (!empty | ovr | ferr). irq asserts one cycle after the causing event.
- Reset asserted mid-frame: the partial frame is discarded, the FIFO is flushed, all state returns to reset values the next cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit.
  - Mismatch against even parity sets perr (STATUS bit8, W1C) and drops the byte.
  - perr also feeds irq.
- Undefined: 8N1 only, no PARITY state, STATUS bit8 reads 0.

Decomposition:
- Package uart_pkg:
  - FSM state encoding.
  - Register offsets DATA/STATUS/CTRL.
  - STATUS bit indices: VALID, OVR, FERR, FULL, PERR.
  - CTRL_IE index.
- One sub-module, uart_rx_fifo: synchronous FIFO.
  - Interface: push, pop, wdata[7:0], rdata[7:0], full, empty, count.
  - Storage: FIFO_DEPTH entries.
  - Simultaneous push and pop are legal in every state.

Test Plan (all with CLKS_PER_BIT=16):
- Single frame 0xA5 (line idle, start, bits LSB-first, stop) -> STATUS reads 0x11. DATA with re reads 0xA5. STATUS then reads 0x00.
- 5 back-to-back frames 0x01..0x05, no reads (FIFO_DEPTH=4) -> STATUS reads 0x4B (count=4, full, ovr, valid). Reads return 0x01..0x04 in order. W1C 0x2 to STATUS clears ovr.
- uart_rxd held 0 from reset release, then 1 -> exactly one ferr (STATUS 0x04), FIFO empty, FSM back in IDLE. A following frame 0x3C is received correctly.
- 3-cycle low glitch on idle line -> no byte pushed, STATUS stays 0x00.
- CTRL=1, receive 0x7E -> irq=1 one cycle after the push. Popping 0x7E drops irq next cycle. With CTRL=0 irq never rises.
- reset pulse in the middle of bit 4 of a frame -> all registers at reset values next cycle, no byte pushed. The next full frame 0x81 is received correctly.
